load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter DEPTH, default 512: number of 32-bit words in the attached data memory.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 req_valid  input  1  pipeline presents a memory request.
REQ-005 req_ready  output  1  unit accepts a request; the request is accepted when req_valid && req_ready.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_funct3  input  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data, right-aligned.
REQ-010 resp_valid  output  1  response available.
REQ-011 resp_ready  input  1  pipeline takes the response.
REQ-012 resp_rdata  output  32  load result, extended to 32 bits; 0 for stores and errors.
REQ-013 resp_err  output  1  misaligned, out-of-range or illegal request.
REQ-014 mem_addr  output  32  word index into the memory, {2'b00, addr[31:2]}.
REQ-015 mem_write_en  output  1  full-word write strobe.
REQ-016 mem_wdata  output  32  write word.
REQ-017 mem_rdata  input  32  combinational read of mem_addr.

Function
REQ-018 The FSM SHALL have these states: IDLE, READ, WRITE, RESP; req_ready SHALL be 1 only in IDLE.
REQ-019 On acceptance, the unit SHALL register we, funct3, addr and wdata; req_* inputs SHALL be ignored outside IDLE.
REQ-020 The request SHALL be an error if any of these hold:
- funct3 is 011, 110 or 111;
- it is a store with funct3[2]=1;
- H/HU with addr[0]=1;
- W with addr[1:0]!=0;
- addr[31:2] >= DEPTH.
REQ-021 An error SHALL go IDLE->RESP with resp_err=1 and resp_rdata=0, with no memory write.
REQ-022 A load SHALL go IDLE->READ->RESP: mem_rdata is sampled at the end of READ, so resp_valid rises 2 cycles after acceptance.
REQ-023 Load extraction SHALL take the byte at lane addr[1:0] or the halfword at lane addr[1]; B/H SHALL sign-extend and BU/HU SHALL zero-extend.
REQ-024 A word store SHALL go IDLE->WRITE->RESP with mem_wdata=wdata.
REQ-025 A byte or halfword store SHALL go IDLE->READ->WRITE->RESP: the old word is sampled in READ, then the addressed lane is replaced with wdata[7:0] or wdata[15:0] and the other lanes are kept.
REQ-026 mem_write_en SHALL be 1 exactly one cycle, only in WRITE.
REQ-027 mem_addr SHALL be held stable from READ through WRITE; in IDLE and RESP it is 0.
REQ-028 RESP SHALL hold resp_valid, resp_rdata and resp_err stable until resp_ready=1, then go to IDLE; the next request can be accepted no earlier than the cycle after the handshake.
REQ-029 resp_valid SHALL be 0 in every state other than RESP.

Reset
REQ-030 While rst=1, the unit SHALL force IDLE, req_ready=1 (once rst is released), resp_valid=0, resp_rdata=0, resp_err=0, mem_write_en=0, mem_addr=0, mem_wdata=0 and clear the captured request.
REQ-031 Reset asserted in any state SHALL abort the operation with no response; reset during WRITE SHALL deassert mem_write_en immediately.

Structure
REQ-032 Package lsu_pkg SHALL hold the funct3 width constants, the state encoding and the lane-select helper constants.
REQ-033 One combinational sub-module, lsu_align, SHALL implement load extraction/extension and store lane merge; the FSM and registers live in load_store_unit.
REQ-034 The target size is 150-300 RTL lines in total.

Verification
REQ-035 Memory word 3 = 0x8040_20F1; LB at addr 0x0C -> resp_rdata 0xFFFF_FFF1, resp_valid 2 cycles after acceptance; LBU at 0x0F -> 0x0000_0080.
REQ-036 SB wdata 0x0000_00AA at addr 0x0D over 0x1122_3344 -> exactly one mem_write_en pulse with mem_wdata 0x1122_AA44; a follow-up LW at 0x0C -> 0x1122_AA44.
REQ-037 SW 0xDEAD_BEEF at 0x10 -> mem_write_en in cycle N+1, resp_valid in N+2, resp_err=0.
REQ-038 Each of these -> resp_err=1 one cycle after acceptance, no write:
- LH at 0x03;
- SW at 0x06;
- LW at 0x800 (DEPTH=512);
- funct3=011.
REQ-039 Backpressure: hold resp_ready=0 for 5 cycles -> response stable and req_ready=0 throughout; release -> IDLE the next cycle.
REQ-040 Assert rst in READ of an SH -> no mem_write_en pulse, no resp_valid, req_ready=1 after release.

Source files
------------

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - width codes, FSM encoding and lane helpers for the load/store unit
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_RESP  = 2'd3
   } lsu_state_t;

   localparam logic [31:0] BYTE_MASK = 32'h0000_00FF;
   localparam logic [31:0] HALF_MASK = 32'h0000_FFFF;

   // Bit offset of the addressed lane; halfword accesses only use addr[1].
   function automatic logic [4:0] lane_offset(input logic [2:0] funct3, input logic [1:0] lane);
      return funct3[0] ? {lane[1], 4'b0000} : {lane, 3'b000};
   endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - load lane extraction/extension and store lane merge
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  lane,
   input  logic [31:0] word,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] store_word
);

   logic [4:0]  off;
   logic [31:0] shifted;
   logic [31:0] mask;

   always_comb begin
      off     = lane_offset(funct3, lane);
      shifted = word >> off;
      mask    = (funct3[0] ? HALF_MASK : BYTE_MASK) << off;

      case (funct3)
         F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
         F3_BU:   load_data = {24'h0, shifted[7:0]};
         F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
         F3_HU:   load_data = {16'h0, shifted[15:0]};
         default: load_data = shifted;
      endcase

      // Read-modify-write: only the addressed lane takes new data.
      if (funct3 == F3_W)
         store_word = wdata;
      else
         store_word = (word & ~mask) | ((wdata << off) & mask);
   end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding RV32I load/store unit over a word memory
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int DEPTH = 512
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] mem_addr,
   output logic        mem_write_en,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   lsu_state_t  state;
   logic        we_q;
   logic [2:0]  funct3_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic        req_err;
   logic [31:0] load_data;
   logic [31:0] store_word;

   assign req_ready = (state == ST_IDLE) && !rst;

   always_comb begin
      case (req_funct3)
         F3_B, F3_BU: req_err = 1'b0;
         F3_H, F3_HU: req_err = req_addr[0];
         F3_W:        req_err = |req_addr[1:0];
         default:     req_err = 1'b1;
      endcase
      if (req_we && req_funct3[2])
         req_err = 1'b1;
      if ({2'b00, req_addr[31:2]} >= 32'(DEPTH))
         req_err = 1'b1;
   end

   lsu_align u_align (
      .funct3     (funct3_q),
      .lane       (addr_q[1:0]),
      .word       (mem_rdata),
      .wdata      (wdata_q),
      .load_data  (load_data),
      .store_word (store_word)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_IDLE;
         we_q         <= 1'b0;
         funct3_q     <= 3'b000;
         addr_q       <= 32'h0;
         wdata_q      <= 32'h0;
         resp_valid   <= 1'b0;
         resp_rdata   <= 32'h0;
         resp_err     <= 1'b0;
         mem_addr     <= 32'h0;
         mem_write_en <= 1'b0;
         mem_wdata    <= 32'h0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  we_q     <= req_we;
                  funct3_q <= req_funct3;
                  addr_q   <= req_addr;
                  wdata_q  <= req_wdata;
                  if (req_err) begin
                     state      <= ST_RESP;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                     resp_rdata <= 32'h0;
                  end else if (req_we && req_funct3 == F3_W) begin
                     state        <= ST_WRITE;
                     mem_addr     <= {2'b00, req_addr[31:2]};
                     mem_write_en <= 1'b1;
                     mem_wdata    <= req_wdata;
                  end else begin
                     state    <= ST_READ;
                     mem_addr <= {2'b00, req_addr[31:2]};
                  end
               end
            end
            ST_READ: begin
               if (we_q) begin
                  state        <= ST_WRITE;
                  mem_addr     <= {2'b00, addr_q[31:2]};
                  mem_write_en <= 1'b1;
                  mem_wdata    <= store_word;
               end else begin
                  state      <= ST_RESP;
                  mem_addr   <= 32'h0;
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b0;
                  resp_rdata <= load_data;
               end
            end
            ST_WRITE: begin
               state        <= ST_RESP;
               mem_addr     <= 32'h0;
               mem_write_en <= 1'b0;
               mem_wdata    <= 32'h0;
               resp_valid   <= 1'b1;
               resp_err     <= 1'b0;
               resp_rdata   <= 32'h0;
            end
            ST_RESP: begin
               if (resp_ready) begin
                  state      <= ST_IDLE;
                  resp_valid <= 1'b0;
                  resp_err   <= 1'b0;
                  resp_rdata <= 32'h0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - randomized self-checking bench for load_store_unit
module tb_load_store_unit;

   localparam int DEPTH = 512;
   localparam int AW    = $clog2(DEPTH);

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'b000;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        resp_valid;
   logic        resp_ready = 1'b1;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] mem_addr;
   logic        mem_write_en;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   int total  = 0;
   int passed = 0;

   always #5 clk = ~clk;

   load_store_unit #(.DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_funct3   (req_funct3),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .resp_valid   (resp_valid),
      .resp_ready   (resp_ready),
      .resp_rdata   (resp_rdata),
      .resp_err     (resp_err),
      .mem_addr     (mem_addr),
      .mem_write_en (mem_write_en),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata)
   );

   // Attached memory (written by DUT or by preload) and the reference copy.
   logic [31:0] mem     [DEPTH];
   logic [31:0] ref_mem [DEPTH];
   logic          pre_we = 1'b0;
   logic [AW-1:0] pre_idx = '0;
   logic [31:0]   pre_data = 32'h0;

   always @(posedge clk) begin
      if (pre_we)
         mem[pre_idx] <= pre_data;
      else if (mem_write_en && mem_addr < 32'(DEPTH))
         mem[mem_addr[AW-1:0]] <= mem_wdata;
   end

   assign mem_rdata = (mem_addr < 32'(DEPTH)) ? mem[mem_addr[AW-1:0]] : 32'h0;

   initial begin
      #1000000;
      $display("FAIL global_timeout: simulation still running at %0t, required finish", $time);
      $fatal(1, "timeout");
   end

   task automatic preload(input int idx, input logic [31:0] d);
      @(negedge clk);
      pre_we   = 1'b1;
      pre_idx  = AW'(idx);
      pre_data = d;
      @(negedge clk);
      pre_we   = 1'b0;
      ref_mem[idx] = d;
   endtask

   // Expected behaviour derived from the width/alignment/range rules.
   task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er,
                        output int lat, output int nwr, output int wlat, output logic [31:0] ww);
      int unsigned idx, lane, sh;
      logic [31:0] old, field, mask;
      idx  = addr / 4;
      lane = addr % 4;
      er = (f3 == 3 || f3 >= 6) || (we && f3 >= 4) ||
           ((f3 == 1 || f3 == 5) && (addr % 2 != 0)) ||
           (f3 == 2 && lane != 0) || (idx >= DEPTH);
      rd = 0; nwr = 0; wlat = 0; ww = 0; lat = 1;
      if (!er) begin
         old = ref_mem[idx];
         if (f3 == 0 || f3 == 4) begin sh = 8 * lane; mask = 32'hFF; end
         else if (f3 == 2) begin sh = 0; mask = 32'hFFFF_FFFF; end
         else begin sh = 16 * (lane / 2); mask = 32'hFFFF; end
         if (!we) begin
            lat   = 2;
            field = (old >> sh) & mask;
            if (f3 == 0 && field >= 128)   field = field + 32'hFFFF_FF00;
            if (f3 == 1 && field >= 32768) field = field + 32'hFFFF_0000;
            rd = field;
         end else begin
            nwr = 1;
            ww  = (old & ~(mask << sh)) | ((wd & mask) << sh);
            ref_mem[idx] = ww;
            lat  = (f3 == 2) ? 2 : 3;
            wlat = (f3 == 2) ? 1 : 2;
         end
      end
   endtask

   // One request; latencies counted in cycles after the acceptance edge.
   task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input int stall,
                         output logic [31:0] rd, output logic er, output int lat,
                         output int nwr, output int wlat, output logic [31:0] ww,
                         output logic rdy_after);
      @(negedge clk);
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wd;
      resp_ready = (stall == 0);
      @(posedge clk);
      #1;
      req_valid  = 1'b0;
      req_we     = 1'($urandom);
      req_funct3 = 3'($urandom);
      req_addr   = $urandom;
      req_wdata  = $urandom;
      lat = 0; nwr = 0; wlat = 0; ww = 0;
      do begin
         @(negedge clk);
         lat++;
         if (mem_write_en) begin
            nwr++;
            wlat = lat;
            ww   = mem_wdata;
         end
      end while (!resp_valid && lat < 12);
      rd = resp_rdata;
      er = resp_err;
      repeat (stall) @(negedge clk);
      resp_ready = 1'b1;
      @(negedge clk);
      rdy_after = req_ready && !resp_valid;
   endtask

   task automatic test_reset();
      @(negedge clk);
      total++; if (resp_valid !== 1'b0) $display("FAIL rst_resp_valid: got %b want 0", resp_valid); else passed++;
      total++; if (resp_rdata !== 32'h0) $display("FAIL rst_resp_rdata: got %h want 0", resp_rdata); else passed++;
      total++; if (resp_err !== 1'b0) $display("FAIL rst_resp_err: got %b want 0", resp_err); else passed++;
      total++; if (mem_write_en !== 1'b0) $display("FAIL rst_mem_write_en: got %b want 0", mem_write_en); else passed++;
      total++; if (mem_addr !== 32'h0) $display("FAIL rst_mem_addr: got %h want 0", mem_addr); else passed++;
      total++; if (mem_wdata !== 32'h0) $display("FAIL rst_mem_wdata: got %h want 0", mem_wdata); else passed++;
      rst = 1'b0;
      @(negedge clk);
      total++; if (req_ready !== 1'b1) $display("FAIL rst_req_ready: got %b want 1", req_ready); else passed++;
   endtask

   task automatic test_loads();
      logic [31:0] rd, ww, erd, eww;
      logic er, eer, rdy;
      int lat, nwr, wlat, elat, enwr, ewlat;
      preload(3, 32'h8040_20F1);
      do_req(1'b0, 3'b000, 32'h0C, 32'h0, 0, rd, er, lat, nwr, wlat, ww, rdy);
      model(1'b0, 3'b000, 32'h0C, 32'h0, erd, eer, elat, enwr, ewlat, eww);
      total++; if (rd !== 32'hFFFF_FFF1) $display("FAIL lb_rdata: got %h want ffff_fff1", rd); else passed++;
      total++; if (lat !== 2) $display("FAIL lb_latency: got %0d want 2", lat); else passed++;
      total++; if (er !== 1'b0) $display("FAIL lb_err: got %b want 0", er); else passed++;
      do_req(1'b0, 3'b100, 32'h0F, 32'h0, 0, rd, er, lat, nwr, wlat, ww, rdy);
      model(1'b0, 3'b100, 32'h0F, 32'h0, erd, eer, elat, enwr, ewlat, eww);
      total++; if (rd !== 32'h0000_0080) $display("FAIL lbu_rdata: got %h want 0000_0080", rd); else passed++;
      total++; if (rdy !== 1'b1) $display("FAIL lbu_idle_after: got %b want 1", rdy); else passed++;
   endtask

   task automatic test_stores();
      logic [31:0] rd, ww, erd, eww;
      logic er, eer, rdy;
      int lat, nwr, wlat, elat, enwr, ewlat;
      preload(3, 32'h1122_3344);
      do_req(1'b1, 3'b000, 32'h0D, 32'h0000_00AA, 0, rd, er, lat, nwr, wlat, ww, rdy);
      model(1'b1, 3'b000, 32'h0D, 32'h0000_00AA, erd, eer, elat, enwr, ewlat, eww);
      total++; if (nwr !== 1) $display("FAIL sb_write_pulses: got %0d want 1", nwr); else passed++;
      total++; if (ww !== 32'h1122_AA44) $display("FAIL sb_mem_wdata: got %h want 1122_aa44", ww); else passed++;
      total++; if (lat !== 3) $display("FAIL sb_latency: got %0d want 3", lat); else passed++;
      do_req(1'b0, 3'b010, 32'h0C, 32'h0, 0, rd, er, lat, nwr, wlat, ww, rdy);
      model(1'b0, 3'b010, 32'h0C, 32'h0, erd, eer, elat, enwr, ewlat, eww);
      total++; if (rd !== 32'h1122_AA44) $display("FAIL lw_after_sb: got %h want 1122_aa44", rd); else passed++;
      do_req(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 0, rd, er, lat, nwr, wlat, ww, rdy);
      model(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, erd, eer, elat, enwr, ewlat, eww);
      total++; if (wlat !== 1) $display("FAIL sw_write_cycle: got %0d want 1", wlat); else passed++;
      total++; if (lat !== 2) $display("FAIL sw_resp_cycle: got %0d want 2", lat); else passed++;
      total++; if (er !== 1'b0) $display("FAIL sw_err: got %b want 0", er); else passed++;
      total++; if (ww !== 32'hDEAD_BEEF) $display("FAIL sw_mem_wdata: got %h want dead_beef", ww); else passed++;
   endtask

   task automatic test_errors();
      logic [31:0] rd, ww;
      logic er, rdy;
      int lat, nwr, wlat;
      logic        t_we   [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
      logic [2:0]  t_f3   [4] = '{3'b001, 3'b010, 3'b010, 3'b011};
      logic [31:0] t_addr [4] = '{32'h3, 32'h6, 32'h800, 32'h0};
      for (int i = 0; i < 4; i++) begin
         do_req(t_we[i], t_f3[i], t_addr[i], 32'h5555_AAAA, 0, rd, er, lat, nwr, wlat, ww, rdy);
         total++; if (er !== 1'b1) $display("FAIL err%0d_flag: got %b want 1", i, er); else passed++;
         total++; if (lat !== 1) $display("FAIL err%0d_latency: got %0d want 1", i, lat); else passed++;
         total++; if (nwr !== 0) $display("FAIL err%0d_writes: got %0d want 0", i, nwr); else passed++;
         total++; if (rd !== 32'h0) $display("FAIL err%0d_rdata: got %h want 0", i, rd); else passed++;
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] erd, eww, hold_d;
      logic eer, hold_e;
      int elat, enwr, ewlat, cnt;
      preload(20, 32'hCAFE_0123);
      model(1'b0, 3'b010, 32'h50, 32'h0, erd, eer, elat, enwr, ewlat, eww);
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h50;
      resp_ready = 1'b0;
      @(posedge clk);
      #1 req_valid = 1'b0;
      cnt = 0;
      do begin @(negedge clk); cnt++; end while (!resp_valid && cnt < 10);
      total++; if (resp_rdata !== erd || resp_valid !== 1'b1)
         $display("FAIL bp_resp: got valid=%b rdata=%h want valid=1 rdata=%h", resp_valid, resp_rdata, erd);
      else passed++;
      hold_d = resp_rdata;
      hold_e = resp_err;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         total++;
         if ({resp_valid, req_ready, resp_err, resp_rdata} !== {1'b1, 1'b0, hold_e, hold_d})
            $display("FAIL bp_hold%0d: got v=%b rdy=%b e=%b d=%h want v=1 rdy=0 e=%b d=%h",
                     c, resp_valid, req_ready, resp_err, resp_rdata, hold_e, hold_d);
         else passed++;
      end
      resp_ready = 1'b1;
      @(negedge clk);
      total++; if (req_ready !== 1'b1 || resp_valid !== 1'b0)
         $display("FAIL bp_release: got rdy=%b v=%b want rdy=1 v=0", req_ready, resp_valid);
      else passed++;
   endtask

   task automatic test_reset_abort();
      int seen;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001; req_addr = 32'h22; req_wdata = $urandom;
      @(posedge clk);
      #1 req_valid = 1'b0;
      total++; if (mem_addr !== 32'd8) $display("FAIL sh_read_addr: got %h want 8", mem_addr); else passed++;
      rst = 1'b1;
      #1;
      total++; if ({mem_write_en, resp_valid, mem_addr} !== {1'b0, 1'b0, 32'h0})
         $display("FAIL abort_outputs: got we=%b v=%b a=%h want 0 0 0", mem_write_en, resp_valid, mem_addr);
      else passed++;
      seen = 0;
      repeat (3) begin @(negedge clk); if (mem_write_en || resp_valid) seen++; end
      rst = 1'b0;
      repeat (3) begin @(negedge clk); if (mem_write_en || resp_valid) seen++; end
      total++; if (seen !== 0) $display("FAIL abort_activity: got %0d active cycles want 0", seen); else passed++;
      total++; if (req_ready !== 1'b1) $display("FAIL abort_ready: got %b want 1", req_ready); else passed++;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h40; req_wdata = $urandom;
      @(posedge clk);
      #1 req_valid = 1'b0;
      total++; if (mem_write_en !== 1'b1) $display("FAIL sw_in_write: got %b want 1", mem_write_en); else passed++;
      rst = 1'b1;
      #1;
      total++; if (mem_write_en !== 1'b0) $display("FAIL write_abort: got %b want 0", mem_write_en); else passed++;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      total++; if (req_ready !== 1'b1 || resp_valid !== 1'b0)
         $display("FAIL write_abort_idle: got rdy=%b v=%b want 1 0", req_ready, resp_valid);
      else passed++;
   endtask

   task automatic test_random();
      logic [31:0] rd, ww, erd, eww, addr, wd;
      logic er, eer, rdy, we;
      logic [2:0] f3;
      int lat, nwr, wlat, elat, enwr, ewlat, stall;
      for (int i = 0; i < 150; i++) begin
         we    = 1'($urandom_range(0, 1));
         f3    = 3'($urandom_range(0, 7));
         addr  = ($urandom_range(0, 15) == 0) ? $urandom : $urandom_range(0, (DEPTH + 4) * 4 - 1);
         wd    = $urandom;
         stall = $urandom_range(0, 2);
         do_req(we, f3, addr, wd, stall, rd, er, lat, nwr, wlat, ww, rdy);
         model(we, f3, addr, wd, erd, eer, elat, enwr, ewlat, eww);
         total++; if (rd !== erd) $display("FAIL rnd%0d_rdata: we=%b f3=%0d a=%h got %h want %h", i, we, f3, addr, rd, erd); else passed++;
         total++; if (er !== eer) $display("FAIL rnd%0d_err: we=%b f3=%0d a=%h got %b want %b", i, we, f3, addr, er, eer); else passed++;
         total++; if (lat !== elat) $display("FAIL rnd%0d_latency: got %0d want %0d", i, lat, elat); else passed++;
         total++; if (nwr !== enwr) $display("FAIL rnd%0d_writes: got %0d want %0d", i, nwr, enwr); else passed++;
         total++; if (wlat !== ewlat) $display("FAIL rnd%0d_write_cycle: got %0d want %0d", i, wlat, ewlat); else passed++;
         total++; if (ww !== eww) $display("FAIL rnd%0d_mem_wdata: got %h want %h", i, ww, eww); else passed++;
         total++; if (rdy !== 1'b1) $display("FAIL rnd%0d_idle_after: got %b want 1", i, rdy); else passed++;
      end
   endtask

   task automatic test_final_mem();
      int bad;
      bad = 0;
      @(negedge clk);
      for (int i = 0; i < DEPTH; i++)
         if (mem[i] !== ref_mem[i]) bad++;
      total++; if (bad !== 0) $display("FAIL final_memory: got %0d differing words want 0", bad); else passed++;
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++)
         preload(i, $urandom);
      test_reset();
      test_loads();
      test_stores();
      test_errors();
      test_backpressure();
      test_reset_abort();
      test_random();
      test_final_mem();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
